// File: rtl/mem_pkg.sv
// Shared encodings and decode helpers for the load/store unit.
package mem_pkg;

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LB   = 4'd1;
    localparam logic [3:0] OP_LH   = 4'd2;
    localparam logic [3:0] OP_LW   = 4'd3;
    localparam logic [3:0] OP_LBU  = 4'd4;
    localparam logic [3:0] OP_LHU  = 4'd5;
    localparam logic [3:0] OP_SB   = 4'd6;
    localparam logic [3:0] OP_SH   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_R,
        DONE
    } lsu_state_e;

    // Unknown encodings are treated like OP_NONE.
    function automatic logic op_is_mem(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_SW);
    endfunction

    function automatic logic [2:0] op_size(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 3'd1;
            OP_LH, OP_LHU, OP_SH: return 3'd2;
            default:              return 3'd4;
        endcase
    endfunction

    function automatic logic op_is_load(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_LHU);
    endfunction

    function automatic logic op_is_signed(input logic [3:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW);
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] addr_lo);
        logic [2:0] size;
        size = op_size(op);
        return ((size == 3'd2) && addr_lo[0]) || ((size == 3'd4) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between the XLEN data path and the memory port, plus load extension.
module lsu_lane_align #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned MEM_DW = 8,
    parameter int unsigned OFF_W  = 1,
    parameter int unsigned BEAT_W = 2
) (
    input  logic [2:0]          size_i,
    input  logic                is_signed_i,
    input  logic [OFF_W-1:0]    off_i,
    input  logic [BEAT_W-1:0]   beat_i,
    input  logic [XLEN-1:0]     st_data_i,
    input  logic [MEM_DW-1:0]   rdata_i,
    input  logic [XLEN-1:0]     asm_i,
    output logic [MEM_DW-1:0]   wdata_o,
    output logic [MEM_DW/8-1:0] be_o,
    output logic [MEM_DW-1:0]   rlane_o,
    output logic [XLEN-1:0]     load_res_o
);
    localparam int unsigned BPB = MEM_DW / 8;

    logic [OFF_W+2:0]  bit_off;
    logic [MEM_DW-1:0] st_beat;
    logic [BPB-1:0]    size_mask;

    assign bit_off = {off_i, 3'b000};

    // Narrow ports pick beat k of the store data; wide ports shift it into its lane.
    assign st_beat   = MEM_DW'(st_data_i >> (32'(beat_i) * MEM_DW));
    assign wdata_o   = st_beat << bit_off;
    assign size_mask = BPB'((32'd1 << size_i) - 32'd1);
    assign be_o      = (32'(size_i) >= BPB) ? '1 : (size_mask << off_i);
    assign rlane_o   = rdata_i >> bit_off;

    always_comb begin
        load_res_o = asm_i;
        unique case (size_i)
            3'd1:    load_res_o = {{(XLEN-8){is_signed_i & asm_i[7]}}, asm_i[7:0]};
            3'd2:    load_res_o = {{(XLEN-16){is_signed_i & asm_i[15]}}, asm_i[15:0]};
            default: load_res_o = asm_i;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM stage load/store unit: splits or lane-steers accesses onto a MEM_DW-wide port and
// stalls the pipeline until the access has completed.
module mem_lsu
    import mem_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned MEM_DW = 8,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          op_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [XLEN-1:0]     st_data_i,
    input  logic [4:0]          waddr_i,
    input  logic                we_i,
    input  logic [XLEN-1:0]     wdata_i,
    output logic [4:0]          waddr_o,
    output logic                we_o,
    output logic [XLEN-1:0]     wdata_o,
    output logic                stallreq_o,
    output logic                misalign_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [MEM_DW/8-1:0] mem_be_o,
    output logic [MEM_DW-1:0]   mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [MEM_DW-1:0]   mem_rdata_i
);
    localparam int unsigned BPB       = MEM_DW / 8;
    localparam int unsigned OFF_W     = (BPB > 1) ? $clog2(BPB) : 1;
    localparam int unsigned MAX_BEATS = XLEN / MEM_DW;
    localparam int unsigned BEAT_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    lsu_state_e        state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [XLEN-1:0]   asm_q, asm_d;

    logic              is_mem, is_load, is_signed, misaligned, aligned_op, last_beat;
    logic [2:0]        size;
    logic [OFF_W-1:0]  off;
    logic [BEAT_W-1:0] last_idx;
    logic [ADDR_W-1:0] beat_addr;
    logic [MEM_DW-1:0] lane_wdata, lane_rdata;
    logic [BPB-1:0]    lane_be;
    logic [XLEN-1:0]   load_res;

    assign is_mem     = op_is_mem(op_i);
    assign is_load    = op_is_load(op_i);
    assign is_signed  = op_is_signed(op_i);
    assign size       = op_size(op_i);
    assign misaligned = is_mem && is_misaligned(op_i, addr_i[1:0]);
    assign aligned_op = is_mem && !misaligned;
    assign off        = (BPB > 1) ? addr_i[OFF_W-1:0] : '0;

    // Only accesses wider than the port need more than one beat.
    assign last_idx  = (32'(size) > BPB) ? BEAT_W'(32'(size) / BPB - 1) : '0;
    assign last_beat = (beat_q == last_idx);
    assign beat_addr = (addr_i & ~ADDR_W'(BPB - 1)) + ADDR_W'(beat_q) * ADDR_W'(BPB);

    lsu_lane_align #(
        .XLEN   (XLEN),
        .MEM_DW (MEM_DW),
        .OFF_W  (OFF_W),
        .BEAT_W (BEAT_W)
    ) u_lane_align (
        .size_i      (size),
        .is_signed_i (is_signed),
        .off_i       (off),
        .beat_i      (beat_q),
        .st_data_i   (st_data_i),
        .rdata_i     (mem_rdata_i),
        .asm_i       (asm_q),
        .wdata_o     (lane_wdata),
        .be_o        (lane_be),
        .rlane_o     (lane_rdata),
        .load_res_o  (load_res)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            asm_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            asm_q   <= asm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        asm_d   = asm_q;
        unique case (state_q)
            IDLE: begin
                if (aligned_op) begin
                    state_d = ISSUE;
                    beat_d  = '0;
                    asm_d   = '0;
                end
            end
            // rvalid seen here belongs to no outstanding read and is dropped.
            ISSUE: begin
                if (mem_gnt_i) begin
                    if (is_load) begin
                        state_d = WAIT_R;
                    end else if (last_beat) begin
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            WAIT_R: begin
                if (mem_rvalid_i) begin
                    for (int b = 0; b < int'(MAX_BEATS); b++) begin
                        if (beat_q == BEAT_W'(b)) begin
                            asm_d[b*MEM_DW +: MEM_DW] = lane_rdata;
                        end
                    end
                    if (last_beat) begin
                        state_d = DONE;
                    end else begin
                        beat_d  = beat_q + BEAT_W'(1);
                        state_d = ISSUE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        waddr_o     = '0;
        we_o        = 1'b0;
        wdata_o     = '0;
        stallreq_o  = 1'b0;
        misalign_o  = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (!rst) begin
            waddr_o    = waddr_i;
            misalign_o = misaligned;
            stallreq_o = aligned_op && (state_q != DONE);
            if (!is_mem) begin
                we_o    = we_i;
                wdata_o = wdata_i;
            end else if (!misaligned) begin
                if (!is_load) begin
                    we_o    = we_i;
                    wdata_o = wdata_i;
                end else if (state_q == DONE) begin
                    we_o    = we_i;
                    wdata_o = load_res;
                end
            end
            if (state_q == ISSUE) begin
                mem_req_o   = 1'b1;
                mem_we_o    = !is_load;
                mem_addr_o  = beat_addr;
                mem_be_o    = lane_be;
                mem_wdata_o = is_load ? '0 : lane_wdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench: an 8-bit-port and a 32-bit-port LSU driven through hand-checked accesses.
module tb_mem_lsu;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // 8-bit memory port instance
    logic [3:0]  a_op = OP_NONE;
    logic [31:0] a_addr = '0, a_st = '0, a_wdata = '0;
    logic [4:0]  a_waddr = '0;
    logic        a_we = 1'b0;
    logic [4:0]  a_waddr_o;
    logic        a_we_o, a_stall, a_mis, a_req, a_mwe;
    logic [31:0] a_wdata_o, a_maddr;
    logic [0:0]  a_be;
    logic [7:0]  a_mwdata;
    logic        a_gnt = 1'b0, a_rvalid = 1'b0;
    logic [7:0]  a_rdata = '0;

    // 32-bit memory port instance
    logic [3:0]  b_op = OP_NONE;
    logic [31:0] b_addr = '0, b_st = '0, b_wdata = '0;
    logic [4:0]  b_waddr = '0;
    logic        b_we = 1'b0;
    logic [4:0]  b_waddr_o;
    logic        b_we_o, b_stall, b_mis, b_req, b_mwe;
    logic [31:0] b_wdata_o, b_maddr;
    logic [3:0]  b_be;
    logic [31:0] b_mwdata;
    logic        b_gnt = 1'b0, b_rvalid = 1'b0;
    logic [31:0] b_rdata = '0;

    mem_lsu #(.XLEN(32), .MEM_DW(8), .ADDR_W(32)) u_dut8 (
        .clk(clk), .rst(rst), .op_i(a_op), .addr_i(a_addr), .st_data_i(a_st),
        .waddr_i(a_waddr), .we_i(a_we), .wdata_i(a_wdata), .waddr_o(a_waddr_o),
        .we_o(a_we_o), .wdata_o(a_wdata_o), .stallreq_o(a_stall), .misalign_o(a_mis),
        .mem_req_o(a_req), .mem_we_o(a_mwe), .mem_addr_o(a_maddr), .mem_be_o(a_be),
        .mem_wdata_o(a_mwdata), .mem_gnt_i(a_gnt), .mem_rvalid_i(a_rvalid),
        .mem_rdata_i(a_rdata)
    );

    mem_lsu #(.XLEN(32), .MEM_DW(32), .ADDR_W(32)) u_dut32 (
        .clk(clk), .rst(rst), .op_i(b_op), .addr_i(b_addr), .st_data_i(b_st),
        .waddr_i(b_waddr), .we_i(b_we), .wdata_i(b_wdata), .waddr_o(b_waddr_o),
        .we_o(b_we_o), .wdata_o(b_wdata_o), .stallreq_o(b_stall), .misalign_o(b_mis),
        .mem_req_o(b_req), .mem_we_o(b_mwe), .mem_addr_o(b_maddr), .mem_be_o(b_be),
        .mem_wdata_o(b_mwdata), .mem_gnt_i(b_gnt), .mem_rvalid_i(b_rvalid),
        .mem_rdata_i(b_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered just after the edge that put dut8 into ISSUE: grant, then one rvalid beat.
    task automatic rd_beat8(input string tag, input logic [31:0] exp_addr, input logic [7:0] d);
        a_gnt = 1'b1;
        @(negedge clk);
        chk({tag, "_req"}, 32'(a_req), 32'd1);
        chk({tag, "_addr"}, a_maddr, exp_addr);
        chk({tag, "_mwe"}, 32'(a_mwe), 32'd0);
        chk({tag, "_stall"}, 32'(a_stall), 32'd1);
        step();
        a_gnt    = 1'b0;
        a_rvalid = 1'b1;
        a_rdata  = d;
        @(negedge clk);
        chk({tag, "_wreq"}, 32'(a_req), 32'd0);
        chk({tag, "_wwe"}, 32'(a_we_o), 32'd0);
        step();
        a_rvalid = 1'b0;
    endtask

    // Store beat with grant held off for two cycles.
    task automatic wr_beat8(input string tag, input logic [31:0] exp_addr, input logic [7:0] d);
        a_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk({tag, "_req"}, 32'(a_req), 32'd1);
            chk({tag, "_addr"}, a_maddr, exp_addr);
            chk({tag, "_data"}, 32'(a_mwdata), 32'(d));
            chk({tag, "_mwe"}, 32'(a_mwe), 32'd1);
            chk({tag, "_stall"}, 32'(a_stall), 32'd1);
            step();
            a_gnt = (i == 1);
        end
        a_gnt = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset gates every output, even a non-memory passthrough.
        a_we    = 1'b1;
        a_wdata = 32'h55;
        a_waddr = 5'd3;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_we", 32'(a_we_o), 32'd0);
        chk("rst_wdata", a_wdata_o, 32'd0);
        chk("rst_waddr", 32'(a_waddr_o), 32'd0);
        chk("rst_req", 32'(a_req) | 32'(b_req), 32'd0);
        step();
        rst = 1'b0;
        a_we = 1'b0;

        // LW @0x100 on the 8-bit port.
        a_op = OP_LW; a_addr = 32'h100; a_we = 1'b1; a_waddr = 5'd5; a_wdata = 32'h0;
        @(negedge clk);
        chk("lw_idle_stall", 32'(a_stall), 32'd1);
        chk("lw_idle_req", 32'(a_req), 32'd0);
        chk("lw_idle_mis", 32'(a_mis), 32'd0);
        step();
        rd_beat8("lw_b0", 32'h100, 8'h11);
        rd_beat8("lw_b1", 32'h101, 8'h22);
        rd_beat8("lw_b2", 32'h102, 8'h33);
        rd_beat8("lw_b3", 32'h103, 8'h84);
        @(negedge clk);
        chk("lw_done_data", a_wdata_o, 32'h84332211);
        chk("lw_done_we", 32'(a_we_o), 32'd1);
        chk("lw_done_waddr", 32'(a_waddr_o), 32'd5);
        chk("lw_done_stall", 32'(a_stall), 32'd0);
        step();
        a_op = OP_NONE; a_we = 1'b0;
        @(negedge clk);
        chk("lw_after_state", 32'(u_dut8.state_q), 32'(IDLE));
        chk("lw_after_we", 32'(a_we_o), 32'd0);

        // LH then LHU @0x202, bytes FE FF.
        step();
        a_op = OP_LH; a_addr = 32'h202; a_we = 1'b1;
        step();
        rd_beat8("lh_b0", 32'h202, 8'hFE);
        rd_beat8("lh_b1", 32'h203, 8'hFF);
        @(negedge clk);
        chk("lh_data", a_wdata_o, 32'hFFFFFFFE);
        step();
        a_op = OP_LHU;
        step();
        rd_beat8("lhu_b0", 32'h202, 8'hFE);
        rd_beat8("lhu_b1", 32'h203, 8'hFF);
        @(negedge clk);
        chk("lhu_data", a_wdata_o, 32'h0000FFFE);
        step();

        // SW 0xDEADBEEF @0x300 with delayed grants.
        a_op = OP_SW; a_addr = 32'h300; a_st = 32'hDEADBEEF; a_we = 1'b0; a_wdata = 32'hAAAA;
        @(negedge clk);
        chk("sw_idle_stall", 32'(a_stall), 32'd1);
        chk("sw_pass_wdata", a_wdata_o, 32'hAAAA);
        step();
        wr_beat8("sw_b0", 32'h300, 8'hEF);
        wr_beat8("sw_b1", 32'h301, 8'hBE);
        wr_beat8("sw_b2", 32'h302, 8'hAD);
        wr_beat8("sw_b3", 32'h303, 8'hDE);
        @(negedge clk);
        chk("sw_done_stall", 32'(a_stall), 32'd0);
        chk("sw_done_req", 32'(a_req), 32'd0);
        chk("sw_done_we", 32'(a_we_o), 32'd0);
        step();
        a_op = OP_NONE;

        // Misaligned LW and plain passthrough.
        a_op = OP_LW; a_addr = 32'h102; a_we = 1'b1;
        @(negedge clk);
        chk("mis_flag", 32'(a_mis), 32'd1);
        chk("mis_stall", 32'(a_stall), 32'd0);
        chk("mis_we", 32'(a_we_o), 32'd0);
        step();
        @(negedge clk);
        chk("mis_req", 32'(a_req), 32'd0);
        step();
        a_op = OP_NONE; a_wdata = 32'h1234; a_we = 1'b1; a_waddr = 5'd7;
        @(negedge clk);
        chk("none_wdata", a_wdata_o, 32'h1234);
        chk("none_we", 32'(a_we_o), 32'd1);
        chk("none_waddr", 32'(a_waddr_o), 32'd7);
        chk("none_stall", 32'(a_stall), 32'd0);
        chk("none_mis", 32'(a_mis), 32'd0);
        step();
        a_we = 1'b0;

        // SB 0x5A @0x103 on the 32-bit port.
        b_op = OP_SB; b_addr = 32'h103; b_st = 32'h1234565A;
        @(negedge clk);
        chk("sb_idle_stall", 32'(b_stall), 32'd1);
        step();
        b_gnt = 1'b1;
        @(negedge clk);
        chk("sb_req", 32'(b_req), 32'd1);
        chk("sb_addr", b_maddr, 32'h100);
        chk("sb_be", 32'(b_be), 32'h8);
        chk("sb_data", b_mwdata, 32'h5A000000);
        chk("sb_mwe", 32'(b_mwe), 32'd1);
        step();
        b_gnt = 1'b0;
        @(negedge clk);
        chk("sb_done_stall", 32'(b_stall), 32'd0);
        step();

        // LH @0x102 on the 32-bit port; a stray rvalid alongside gnt is ignored.
        b_op = OP_LH; b_addr = 32'h102; b_we = 1'b1;
        step();
        b_gnt = 1'b1; b_rvalid = 1'b1; b_rdata = 32'h11111111;
        @(negedge clk);
        chk("lh32_be", 32'(b_be), 32'hC);
        chk("lh32_addr", b_maddr, 32'h100);
        step();
        b_gnt = 1'b0; b_rvalid = 1'b1; b_rdata = 32'h80017F7F;
        step();
        b_rvalid = 1'b0;
        @(negedge clk);
        chk("lh32_data", b_wdata_o, 32'hFFFF8001);
        chk("lh32_we", 32'(b_we_o), 32'd1);
        step();
        b_op = OP_NONE; b_we = 1'b0;

        // Reset after two LW beats, late rvalid, then a clean LB.
        a_op = OP_LW; a_addr = 32'h100; a_we = 1'b1;
        step();
        rd_beat8("rl_b0", 32'h100, 8'h01);
        rd_beat8("rl_b1", 32'h101, 8'h02);
        rst = 1'b1;
        @(negedge clk);
        chk("rl_rst_req", 32'(a_req), 32'd0);
        chk("rl_rst_stall", 32'(a_stall), 32'd0);
        step();
        a_op = OP_NONE; a_we = 1'b0;
        @(negedge clk);
        chk("rl_state", 32'(u_dut8.state_q), 32'(IDLE));
        chk("rl_wdata", a_wdata_o, 32'd0);
        step();
        rst = 1'b0;
        a_rvalid = 1'b1; a_rdata = 8'h77;
        step();
        a_rvalid = 1'b0;
        @(negedge clk);
        chk("rl_late_state", 32'(u_dut8.state_q), 32'(IDLE));
        chk("rl_late_req", 32'(a_req), 32'd0);
        step();
        a_op = OP_LB; a_addr = 32'h105; a_we = 1'b1;
        step();
        rd_beat8("lb_b0", 32'h105, 8'h80);
        @(negedge clk);
        chk("lb_data", a_wdata_o, 32'hFFFFFF80);
        chk("lb_we", 32'(a_we_o), 32'd1);
        step();
        a_op = OP_NONE; a_we = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
